// File: rtl/multicycle_datapath.sv
// multicycle_datapath: MIPS-subset multicycle core with a single shared memory port.
// Memory and status outputs decode the registered state so FETCH costs no extra cycle.
module multicycle_datapath #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          REG_COUNT  = 32,
    parameter bit          ALLOW_WAIT = 1'b1
) (
    input  logic        CLK,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] PC,
    output logic [2:0]  state,
    output logic        retire,
    output logic        illegal
);
    localparam int IW = $clog2(REG_COUNT);
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;

    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;

    state_t st;
    logic [31:0] ir, a, b, alu_out, mdr, sign_imm, alu_r;
    logic [31:0] regs [REG_COUNT];
    logic [5:0] op, funct;
    logic [IW-1:0] rs, rt, rd, dst;
    logic rdy, op_ok, funct_ok;

    assign op       = ir[31:26];
    assign funct    = ir[5:0];
    assign rs       = ir[21+IW-1:21];
    assign rt       = ir[16+IW-1:16];
    assign rd       = ir[11+IW-1:11];
    assign dst      = (op == OP_R) ? rd : rt;
    assign sign_imm = {{16{ir[15]}}, ir[15:0]};
    assign rdy      = ALLOW_WAIT ? mem_ready : 1'b1;
    assign op_ok    = op inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
    assign funct_ok = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    assign alu_r = (funct == 6'h22) ? a - b :
                   (funct == 6'h24) ? a & b :
                   (funct == 6'h25) ? a | b :
                   (funct == 6'h2A) ? {31'b0, $signed(a) < $signed(b)} : a + b;

    assign state     = st;
    assign mem_req   = !reset && (st == FETCH || st == MEM);
    assign mem_we    = (st == MEM) && (op == OP_SW);
    assign mem_addr  = (st == MEM) ? alu_out : PC;
    assign mem_wdata = b;
    assign retire    = !reset && ((st == DECODE && op == OP_J) || (st == EXEC && op == OP_BEQ) ||
                                  (st == MEM && op == OP_SW && rdy) || st == WB);
    assign illegal   = !reset && ((st == DECODE && !op_ok) || (st == EXEC && op == OP_R && !funct_ok));

    always_ff @(posedge CLK) begin
        if (reset) begin
            st      <= FETCH;
            PC      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            case (st)
                FETCH: if (rdy) begin
                    ir <= mem_rdata;
                    PC <= PC + 32'd4;
                    st <= DECODE;
                end
                DECODE: begin
                    a  <= regs[rs];
                    b  <= regs[rt];
                    st <= (op == OP_J || !op_ok) ? FETCH : EXEC;
                    if (op == OP_J) PC <= {PC[31:28], ir[25:0], 2'b00};
                end
                EXEC: begin
                    alu_out <= (op == OP_R) ? alu_r : a + sign_imm;
                    if (op == OP_BEQ && a == b) PC <= PC + (sign_imm << 2);
                    st <= (op == OP_BEQ || (op == OP_R && !funct_ok)) ? FETCH :
                          (op == OP_LW || op == OP_SW) ? MEM : WB;
                end
                MEM: if (rdy) begin
                    mdr <= mem_rdata;
                    st  <= (op == OP_LW) ? WB : FETCH;
                end
                WB: begin
                    // regs[0] is never written, so it always reads back as zero
                    if (dst != '0) regs[dst] <= (op == OP_LW) ? mdr : alu_out;
                    st <= FETCH;
                end
                default: st <= FETCH;
            endcase
        end
    end
endmodule
